// File: rtl/pistormx_pkg.sv
// Shared definitions for the PistormX bus arbiter: state encoding, default grant timeout
// and the placement of the arbiter state inside the Pi-visible REG_STATUS word.
package pistormx_pkg;

  typedef enum logic [1:0] {
    OWNED   = 2'd0,
    GRANT   = 2'd1,
    GRANTED = 2'd2,
    RECLAIM = 2'd3
  } arb_state_e;

  localparam int DEFAULT_GRANT_TIMEOUT = 15;

  localparam int REG_STATUS_ARB_LSB = 11;
  localparam int REG_STATUS_ARB_MSB = REG_STATUS_ARB_LSB + 1;

  // Drops the arbiter state into an otherwise-empty REG_STATUS word for OR-merging.
  function automatic logic [15:0] status_arb_field(input logic [1:0] arb_state);
    logic [15:0] word;
    word = '0;
    word[REG_STATUS_ARB_MSB:REG_STATUS_ARB_LSB] = arb_state;
    return word;
  endfunction

endpackage

// File: rtl/pistormx_sync.sv
// Reset-to-1 synchronizer chain for the active-low 68000 arbitration pins.
// Latency: SYNC_STAGES c7m falling edges; no backpressure.
module pistormx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic c7m,
  input  logic op_reqrst,
  input  logic async_i,
  output logic sync_o
);

  logic [SYNC_STAGES-1:0] chain_q;

  always_ff @(negedge c7m or posedge op_reqrst) begin
    if (op_reqrst) begin
      chain_q <= '1;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], async_i};
    end
  end

  assign sync_o = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/pistormx_bus_arbiter.sv
// 68000 bus-mastership arbiter: Pi engine vs BR/BG/BGACK DMA masters, all outputs registered on c7m fall.
// Optional grant watchdog enabled by PISTORMX_GRANT_TIMEOUT_EN.
module pistormx_bus_arbiter
  import pistormx_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int GRANT_TIMEOUT = DEFAULT_GRANT_TIMEOUT
) (
  input  logic       c7m,
  input  logic       op_reqrst,
  input  logic       m68k_br_n,
  input  logic       m68k_bgack_n,
  input  logic       cycle_idle,
  input  logic       op_req,
  output logic       start_ok,
  output logic       bus_release,
  output logic       m68k_bg_n,
  output logic [1:0] arb_state,
  output logic       arb_err
);

  logic br_sync_n;
  logic bgack_sync_n;
  logic br_s;
  logic bgack_s;

  pistormx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_br (
    .c7m      (c7m),
    .op_reqrst(op_reqrst),
    .async_i  (m68k_br_n),
    .sync_o   (br_sync_n)
  );

  pistormx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bgack (
    .c7m      (c7m),
    .op_reqrst(op_reqrst),
    .async_i  (m68k_bgack_n),
    .sync_o   (bgack_sync_n)
  );

  assign br_s    = ~br_sync_n;
  assign bgack_s = ~bgack_sync_n;

  arb_state_e state_q, state_d;
  logic       bg_n_q, bg_n_d;
  logic       bus_release_q, bus_release_d;
  logic       start_ok_q, start_ok_d;
  logic       grant_expired;
  logic       grant_blocked;

`ifdef PISTORMX_GRANT_TIMEOUT_EN
  localparam int CNT_W = $clog2(GRANT_TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             hold_q, hold_d;

  assign grant_expired = (state_q == GRANT) && (cnt_q == CNT_W'(GRANT_TIMEOUT - 1));
  // After a watchdog withdrawal, re-grant only once the requester has let go of BR.
  assign grant_blocked = hold_q;

  always_comb begin
    cnt_d  = '0;
    err_d  = err_q;
    hold_d = hold_q;
    if (state_q == GRANT) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (grant_expired && !bgack_s && br_s) begin
      err_d  = 1'b1;
      hold_d = 1'b1;
    end else if (!br_s) begin
      hold_d = 1'b0;
    end
  end

  always_ff @(negedge c7m or posedge op_reqrst) begin
    if (op_reqrst) begin
      cnt_q  <= '0;
      err_q  <= 1'b0;
      hold_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      hold_q <= hold_d;
    end
  end

  assign arb_err = err_q;
`else
  assign grant_expired = 1'b0;
  assign grant_blocked = 1'b0;
  assign arb_err       = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      OWNED: begin
        if (bgack_s) begin
          state_d = GRANTED;
        end else if (br_s && cycle_idle && !grant_blocked) begin
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (bgack_s) begin
          state_d = GRANTED;
        end else if (!br_s || grant_expired) begin
          state_d = OWNED;
        end
      end
      GRANTED: begin
        if (!bgack_s) begin
          state_d = RECLAIM;
        end
      end
      RECLAIM: begin
        state_d = br_s ? GRANT : OWNED;
      end
      default: state_d = OWNED;
    endcase

    // Outputs follow the next state so every pin moves on the same edge as the state.
    bg_n_d        = (state_d != GRANT);
    bus_release_d = (state_d != OWNED);
    start_ok_d    = (state_d == OWNED) && !br_s;
  end

  always_ff @(negedge c7m or posedge op_reqrst) begin
    if (op_reqrst) begin
      state_q       <= OWNED;
      bg_n_q        <= 1'b1;
      bus_release_q <= 1'b0;
      start_ok_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      bg_n_q        <= bg_n_d;
      bus_release_q <= bus_release_d;
      start_ok_q    <= start_ok_d;
    end
  end

  assign arb_state   = state_q;
  assign m68k_bg_n   = bg_n_q;
  assign bus_release = bus_release_q;
  assign start_ok    = start_ok_q;

  // A pending Pi request is simply held off by start_ok; the arbiter never needs to see it.
  logic unused_ok;
  assign unused_ok = op_req;

endmodule

// File: tb/tb_pistormx_bus_arbiter.sv
// Directed bench for pistormx_bus_arbiter; covers the watchdog path when PISTORMX_GRANT_TIMEOUT_EN is defined.
module tb_pistormx_bus_arbiter;

  logic       c7m = 1'b0;
  logic       op_reqrst;
  logic       m68k_br_n;
  logic       m68k_bgack_n;
  logic       cycle_idle;
  logic       op_req;
  logic       start_ok;
  logic       bus_release;
  logic       m68k_bg_n;
  logic [1:0] arb_state;
  logic       arb_err;

  int checks = 0;
  int errors = 0;

  always #5 c7m = ~c7m;

  pistormx_bus_arbiter dut (
    .c7m         (c7m),
    .op_reqrst   (op_reqrst),
    .m68k_br_n   (m68k_br_n),
    .m68k_bgack_n(m68k_bgack_n),
    .cycle_idle  (cycle_idle),
    .op_req      (op_req),
    .start_ok    (start_ok),
    .bus_release (bus_release),
    .m68k_bg_n   (m68k_bg_n),
    .arb_state   (arb_state),
    .arb_err     (arb_err)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge c7m);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic chk_all(input string tag, input int st, input int bg_n, input int rel, input int ok);
    chk({tag, ".state"}, 32'(arb_state), 32'(st));
    chk({tag, ".bg_n"}, 32'(m68k_bg_n), 32'(bg_n));
    chk({tag, ".release"}, 32'(bus_release), 32'(rel));
    chk({tag, ".start_ok"}, 32'(start_ok), 32'(ok));
  endtask

  initial begin
    op_reqrst    = 1'b1;
    m68k_br_n    = 1'b1;
    m68k_bgack_n = 1'b1;
    cycle_idle   = 1'b1;
    op_req       = 1'b0;

    // Reset state, then start_ok on the first edge after release.
    #12;
    chk_all("reset", 0, 1, 0, 0);
    chk("reset.err", 32'(arb_err), 0);
    op_reqrst = 1'b0;
    tick(1);
    chk_all("post_reset", 0, 1, 0, 1);

    // BR during a busy cycle: start_ok drops after SYNC_STAGES+1 edges, no grant until idle.
    m68k_br_n  = 1'b0;
    cycle_idle = 1'b0;
    op_req     = 1'b1;
    tick(2);
    chk("busy.start_ok_e2", 32'(start_ok), 1);
    tick(1);
    chk_all("busy.e3", 0, 1, 0, 0);
    tick(2);
    chk_all("busy.e5", 0, 1, 0, 0);
    cycle_idle = 1'b1;
    tick(1);
    chk_all("grant", 1, 0, 1, 0);

    // Full DMA handshake.
    m68k_bgack_n = 1'b0;
    tick(2);
    chk_all("bgack_sync", 1, 0, 1, 0);
    tick(1);
    chk_all("granted", 2, 1, 1, 0);
    m68k_br_n = 1'b1;
    op_req    = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("dma.release", 32'(bus_release), 1);
    end
    m68k_bgack_n = 1'b1;
    tick(2);
    chk_all("dma.hold", 2, 1, 1, 0);
    tick(1);
    chk_all("reclaim", 3, 1, 1, 0);
    tick(1);
    chk_all("reclaimed", 0, 1, 0, 1);

    // BR withdrawn while in GRANT with no BGACK.
    m68k_br_n = 1'b0;
    tick(3);
    chk_all("wd.grant", 1, 0, 1, 0);
    m68k_br_n = 1'b1;
    tick(2);
    chk("wd.still_grant", 32'(arb_state), 1);
    tick(1);
    chk_all("wd.owned", 0, 1, 0, 1);
    chk("wd.err", 32'(arb_err), 0);

    // Grant that is never acknowledged.
    m68k_br_n = 1'b0;
    tick(3);
    chk("to.grant", 32'(arb_state), 1);
`ifdef PISTORMX_GRANT_TIMEOUT_EN
    tick(14);
    chk("to.e14.state", 32'(arb_state), 1);
    chk("to.e14.bg_n", 32'(m68k_bg_n), 0);
    tick(1);
    chk_all("to.e15", 0, 1, 0, 0);
    chk("to.err", 32'(arb_err), 1);
    tick(2);
    chk("to.no_regrant", 32'(arb_state), 0);
    m68k_br_n = 1'b1;
    tick(4);
    chk("to.err_sticky", 32'(arb_err), 1);
    chk_all("to.released", 0, 1, 0, 1);
`else
    tick(30);
    chk_all("nto.waiting", 1, 0, 1, 0);
    chk("nto.err", 32'(arb_err), 0);
    m68k_br_n = 1'b1;
    tick(3);
    chk_all("nto.released", 0, 1, 0, 1);
`endif

    // Reset mid-grant with BGACK still held.
    m68k_br_n = 1'b0;
    tick(3);
    chk("rg.grant", 32'(arb_state), 1);
    m68k_bgack_n = 1'b0;
    tick(3);
    chk("rg.granted", 32'(arb_state), 2);
    op_reqrst = 1'b1;
    m68k_br_n = 1'b1;
    op_req    = 1'b1;
    #1;
    chk_all("rg.async", 0, 1, 0, 0);
    #1;
    op_reqrst = 1'b0;
    tick(3);
    chk_all("rg.regranted", 2, 1, 1, 0);
    chk("rg.err_cleared", 32'(arb_err), 0);
    tick(4);
    chk("rg.no_start", 32'(start_ok), 0);
    m68k_bgack_n = 1'b1;
    tick(2);
    chk_all("rg.hold", 2, 1, 1, 0);
    tick(1);
    chk_all("rg.reclaim", 3, 1, 1, 0);
    tick(1);
    chk_all("rg.owned", 0, 1, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
